// File: rtl/conv_out_normalizer.sv
// Convolution output normalizer: optional |x|, rounding right-shift and clamp to
// a BITW-bit pixel, framed as an (WIDTH-2) x (HEIGHT-2) image with line/frame
// markers, a per-frame saturation count, and frame-done / overrun flags.
module conv_out_normalizer #(
    parameter int unsigned ACCW   = 20,
    parameter int unsigned BITW   = 8,
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256
) (
    input  logic                   i_CLK,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic signed [ACCW-1:0] i_conv,
    input  logic [3:0]             i_shift,
    input  logic                   i_abs_mode,
    output logic                   o_valid,
    output logic [BITW-1:0]        o_pixel,
    output logic                   o_eol,
    output logic                   o_eof,
    output logic                   o_frame_done,
    output logic                   o_overrun,
    output logic [15:0]            o_sat_count
);

    localparam int unsigned OW    = WIDTH - 2;
    localparam int unsigned OH    = HEIGHT - 2;
    localparam int unsigned TOTAL = OW * OH;
    localparam int unsigned CNTW  = $clog2(TOTAL + 1);
    localparam int unsigned COLW  = $clog2(OW + 1);
    localparam int unsigned ROWW  = $clog2(OH + 1);
    localparam int unsigned SATW  = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [CNTW-1:0]        in_cnt;
    logic [3:0]             cfg_shift;
    logic                   cfg_abs;

    logic                   s1_valid;
    logic signed [ACCW:0]   s1_data;
    logic [3:0]             s1_shift;
    logic                   s2_valid;
    logic signed [ACCW:0]   s2_data;

    logic [COLW-1:0]        col;
    logic [ROWW-1:0]        row;

    logic                   frame_start_c;
    logic                   accept_c;
    logic [3:0]             shift_c;
    logic                   abs_c;
    logic [CNTW-1:0]        in_cnt_nxt_c;
    logic                   last_in_c;

    logic signed [ACCW:0]   ext_c;
    logic signed [ACCW:0]   mag_c;
    logic [ACCW:0]          half_c;
    logic signed [ACCW:0]   rnd_c;

    logic                   neg_c;
    logic                   over_c;
    logic                   sat_c;
    logic [BITW-1:0]        pix_c;
    logic                   eol_c;
    logic                   eof_c;

    // Frame-start detection and the config that applies to the current sample
    always_comb begin
        frame_start_c = i_valid && ((state == S_IDLE) || (state == S_DONE));
        accept_c      = i_valid && (state != S_DRAIN);
        shift_c       = frame_start_c ? i_shift : cfg_shift;
        abs_c         = frame_start_c ? i_abs_mode : cfg_abs;
        in_cnt_nxt_c  = frame_start_c ? CNTW'(1) : (in_cnt + CNTW'(1));
        last_in_c     = accept_c && (in_cnt_nxt_c == CNTW'(TOTAL));
    end

    // Stage 1 datapath: sign-extend, optional magnitude, add half-LSB for rounding
    always_comb begin
        ext_c  = $signed({i_conv[ACCW-1], i_conv});
        mag_c  = (abs_c && ext_c[ACCW]) ? -ext_c : ext_c;
        half_c = (shift_c == 4'd0) ? '0 : ((ACCW+1)'(1) << (shift_c - 4'd1));
        rnd_c  = mag_c + $signed(half_c);
    end

    // Stage 3 datapath: clamp to pixel range and locate the pixel in the frame
    always_comb begin
        neg_c  = s2_data[ACCW];
        over_c = !neg_c && (|s2_data[ACCW-1:BITW]);
        sat_c  = neg_c || over_c;
        if (neg_c) begin
            pix_c = '0;
        end else if (over_c) begin
            pix_c = '1;
        end else begin
            pix_c = s2_data[BITW-1:0];
        end
        eol_c = (col == COLW'(OW - 1));
        eof_c = eol_c && (row == ROWW'(OH - 1));
    end

    // Frame FSM, config latch, input count and sticky status flags
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state        <= S_IDLE;
            in_cnt       <= '0;
            cfg_shift    <= '0;
            cfg_abs      <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (frame_start_c) begin
                cfg_shift    <= i_shift;
                cfg_abs      <= i_abs_mode;
                o_frame_done <= 1'b0;
                o_overrun    <= 1'b0;
            end
            if (accept_c) begin
                in_cnt <= in_cnt_nxt_c;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_valid) begin
                        state <= last_in_c ? S_DRAIN : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (last_in_c) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (o_eof) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // DONE is entered only at eof, so this never collides with a frame start
            if (o_eof) begin
                o_frame_done <= 1'b1;
            end
        end
    end

    // Stages 1 and 2: register the rounded value, then arithmetic shift
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s1_valid <= accept_c;
            s1_data  <= rnd_c;
            s1_shift <= shift_c;
            s2_valid <= s1_valid;
            s2_data  <= s1_data >>> s1_shift;
        end
    end

    // Stage 3: registered pixel with markers, frame position and saturation count
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_pixel     <= '0;
            o_eol       <= 1'b0;
            o_eof       <= 1'b0;
            o_sat_count <= '0;
            col         <= '0;
            row         <= '0;
        end else begin
            o_valid <= s2_valid;
            o_pixel <= s2_valid ? pix_c : '0;
            o_eol   <= s2_valid && eol_c;
            o_eof   <= s2_valid && eof_c;
            if (frame_start_c) begin
                col         <= '0;
                row         <= '0;
                o_sat_count <= '0;
            end else if (s2_valid) begin
                if (eol_c) begin
                    col <= '0;
                    row <= eof_c ? '0 : (row + ROWW'(1));
                end else begin
                    col <= col + COLW'(1);
                end
                if (sat_c && (o_sat_count != {SATW{1'b1}})) begin
                    o_sat_count <= o_sat_count + SATW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_out_normalizer.sv
// Self-checking bench for conv_out_normalizer on a 5x4 input image (3x2 output).
module tb_conv_out_normalizer;

    localparam int ACCW   = 20;
    localparam int BITW   = 8;
    localparam int WIDTH  = 5;
    localparam int HEIGHT = 4;
    localparam int OW     = WIDTH - 2;
    localparam int OH     = HEIGHT - 2;
    localparam int TOTAL  = OW * OH;

    typedef struct {
        logic [BITW-1:0] pix;
        bit              eol;
        bit              eof;
        bit              sat;
        bit              first;
        int              cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   i_valid = 1'b0;
    logic signed [ACCW-1:0] i_conv = '0;
    logic [3:0]             i_shift = '0;
    logic                   i_abs = 1'b0;
    logic                   o_valid;
    logic [BITW-1:0]        o_pixel;
    logic                   o_eol;
    logic                   o_eof;
    logic                   o_frame_done;
    logic                   o_overrun;
    logic [15:0]            o_sat_count;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sbq[$];
    exp_t mon_e;

    // reference model state
    bit   m_started = 1'b0;
    int   m_cnt = 0;
    bit   m_eof_seen = 1'b0;
    int   m_shift = 0;
    bit   m_abs = 1'b0;
    int   m_sat = 0;
    int   frame_outs = 0;

    conv_out_normalizer #(
        .ACCW   (ACCW),
        .BITW   (BITW),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .i_CLK        (clk),
        .i_reset      (rst),
        .i_valid      (i_valid),
        .i_conv       (i_conv),
        .i_shift      (i_shift),
        .i_abs_mode   (i_abs),
        .o_valid      (o_valid),
        .o_pixel      (o_pixel),
        .o_eol        (o_eol),
        .o_eof        (o_eof),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun),
        .o_sat_count  (o_sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output is popped and compared against the model
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output pixel=%0d cyc=%0d", o_pixel, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.first) begin
                    m_sat = 0;
                    frame_outs = 0;
                end
                if (mon_e.sat && m_sat < 65535) m_sat++;
                frame_outs++;
                checks++;
                if (o_pixel !== mon_e.pix) begin
                    failures++;
                    $display("FAIL pixel got=%0d exp=%0d", o_pixel, mon_e.pix);
                end
                checks++;
                if (o_eol !== mon_e.eol) begin
                    failures++;
                    $display("FAIL eol got=%0b exp=%0b", o_eol, mon_e.eol);
                end
                checks++;
                if (o_eof !== mon_e.eof) begin
                    failures++;
                    $display("FAIL eof got=%0b exp=%0b", o_eof, mon_e.eof);
                end
                checks++;
                if (o_sat_count !== 16'(m_sat)) begin
                    failures++;
                    $display("FAIL sat_count got=%0d exp=%0d", o_sat_count, m_sat);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL latency out_cyc=%0d exp_cyc=%0d", cyc, mon_e.cyc);
                end
                if (mon_e.eof) m_eof_seen = 1'b1;
            end
        end else begin
            checks++;
            if ({o_pixel, o_eol, o_eof} !== '0) begin
                failures++;
                $display("FAIL idle_zero pixel=%0d eol=%0b eof=%0b", o_pixel, o_eol, o_eof);
            end
        end
    end

    // Drive one sample on the next cycle and push its expected result
    task automatic send(input int conv, input int sh, input bit ab);
        exp_t   e;
        longint v;
        int     k;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_conv  = ACCW'(conv);
        i_shift = 4'(sh);
        i_abs   = ab;
        if (m_started && m_cnt == TOTAL && !m_eof_seen) begin
            return; // dropped while draining
        end
        e.first = 1'b0;
        if (!m_started || m_cnt == TOTAL) begin
            m_started  = 1'b1;
            m_cnt      = 0;
            m_eof_seen = 1'b0;
            m_shift    = sh;
            m_abs      = ab;
            e.first    = 1'b1;
        end
        m_cnt++;
        k = m_cnt - 1;
        v = conv;
        if (m_abs && v < 0) v = -v;
        if (m_shift > 0) v = v + (longint'(1) << (m_shift - 1));
        v = v >>> m_shift;
        if (v < 0) begin
            e.pix = '0; e.sat = 1'b1;
        end else if (v > 255) begin
            e.pix = 8'hFF; e.sat = 1'b1;
        end else begin
            e.pix = BITW'(v); e.sat = 1'b0;
        end
        e.eol = ((k % OW) == OW - 1);
        e.eof = (k == TOTAL - 1);
        e.cyc = cyc + 3;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_valid, o_pixel, o_eol, o_eof, o_frame_done, o_overrun, o_sat_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {o_valid, o_pixel, o_eol, o_eof, o_frame_done, o_overrun, o_sat_count});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_frame_done, o_overrun, o_sat_count} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%0h exp=0",
                     {o_valid, o_frame_done, o_overrun, o_sat_count});
        end
    endtask

    task automatic test_passthrough();
        send(0, 0, 0); send(5, 0, 0); send(255, 0, 0);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
        idle(1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (o_sat_count !== 16'd0) begin
            failures++;
            $display("FAIL passthrough_sat got=%0d exp=0", o_sat_count);
        end
        checks++;
        if (o_frame_done !== 1'b1) begin
            failures++;
            $display("FAIL passthrough_done got=%0b exp=1", o_frame_done);
        end
    endtask

    task automatic test_shift_round();
        send(24, 4, 0); send(7, 4, 0); send(4095, 4, 0);
        send(8, 4, 0); send(-8, 4, 0); send(40, 4, 0);
        idle(1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (o_sat_count !== 16'd1) begin
            failures++;
            $display("FAIL shift_sat_count got=%0d exp=1", o_sat_count);
        end
    endtask

    task automatic test_abs();
        send(-100, 0, 0); send(10, 0, 0); send(20, 0, 0);
        send(30, 0, 0); send(40, 0, 0); send(50, 0, 0);
        idle(1);
        wait_drain();
        send(-100, 0, 1); send(-524288, 0, 1); send(3, 0, 1);
        send(-3, 0, 1); send(0, 0, 1); send(1, 0, 1);
        idle(1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (o_sat_count !== 16'd1) begin
            failures++;
            $display("FAIL abs_sat_count got=%0d exp=1", o_sat_count);
        end
    endtask

    task automatic test_frame_markers();
        bit got = 1'b0;
        for (int i = 1; i <= TOTAL; i++) send(i, 0, 0);
        idle(1);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (o_eof === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL eof_timeout got=0 exp=1");
        end else begin
            checks++;
            if (o_frame_done !== 1'b0) begin
                failures++;
                $display("FAIL done_at_eof got=%0b exp=0", o_frame_done);
            end
            @(negedge clk);
            checks++;
            if (o_frame_done !== 1'b1) begin
                failures++;
                $display("FAIL done_after_eof got=%0b exp=1", o_frame_done);
            end
        end
        send(9, 0, 0);
        idle(1);
        @(negedge clk);
        checks++;
        if (o_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL done_clear_on_start got=%0b exp=0", o_frame_done);
        end
        for (int i = 0; i < TOTAL - 1; i++) send(10 + i, 0, 0);
        idle(1);
        wait_drain();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < TOTAL; i++) send(20 + i, 0, 0);
        send(77, 0, 0);
        idle(1);
        @(negedge clk);
        checks++;
        if (o_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got=%0b exp=1", o_overrun);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        checks++;
        if (frame_outs != TOTAL) begin
            failures++;
            $display("FAIL overrun_out_count got=%0d exp=%0d", frame_outs, TOTAL);
        end
        send(5, 0, 0);
        idle(1);
        @(negedge clk);
        checks++;
        if (o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%0b exp=0", o_overrun);
        end
        for (int i = 0; i < TOTAL - 1; i++) send(6 + i, 0, 0);
        idle(1);
        wait_drain();
    endtask

    task automatic test_cfg_hold();
        send(50, 0, 0);
        for (int i = 0; i < TOTAL - 1; i++) send(50, 4, 1);
        idle(1);
        wait_drain();
        for (int i = 0; i < TOTAL; i++) send(50, 4, 0);
        idle(1);
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        repeat (4) send(-5, 0, 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk); #1;
        sbq.delete();
        m_started  = 1'b0;
        m_cnt      = 0;
        m_eof_seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_pixel, o_eol, o_eof, o_frame_done, o_overrun, o_sat_count} !== '0) begin
                failures++;
                $display("FAIL midflight_reset got=%0h exp=0",
                         {o_valid, o_pixel, o_eol, o_eof, o_frame_done, o_overrun, o_sat_count});
            end
        end
        for (int i = 1; i <= TOTAL; i++) send(i, 1, 0);
        idle(1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (o_frame_done !== 1'b1) begin
            failures++;
            $display("FAIL frame_after_reset_done got=%0b exp=1", o_frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_shift_round();
        test_abs();
        test_frame_markers();
        test_overrun();
        test_cfg_hold();
        test_reset_midflight();
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
